operand_fetch: RTL

//  Initiator side of the register file interface. Accepts one decoded instruction at a

---
 rtl/operand_fetch.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Register-file initiator. Holds one decoded instruction, stalls
//             on pending writes (RAW and WAW), forwards same-cycle writeback
//             data and presents operands to execute. Owns the regfile write
//             port and a pending-write scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_wr,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  output logic            rf_renb1,
  output logic            rf_renb2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [AW-1:0]   rf_rd,
  output logic            rf_wenb,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_wr,
  output logic            sb_err
);

  localparam int C_NREG = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t            r_state;
  logic [AW-1:0]     r_rs1;
  logic [AW-1:0]     r_rs2;
  logic [AW-1:0]     r_rd;
  logic              r_use1;
  logic              r_use2;
  logic              r_wr;
  logic [C_NREG-1:0] r_pend;
  logic              r_sb_err;
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_op1;
  logic [XLEN-1:0]   r_ex_op2;
  logic [AW-1:0]     r_ex_rd;
  logic              r_ex_wr;

  logic              w_id_fire;
  logic              w_ex_fire;
  logic              w_wb_wr;
  logic [C_NREG-1:0] w_wb_hit;
  logic [C_NREG-1:0] w_pend_eff;
  logic              w_hazard;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;

  assign id_ready  = (r_state == S_IDLE) | ((r_state == S_ISSUE) & ex_ready);
  assign w_id_fire = id_valid & id_ready;
  assign w_ex_fire = r_ex_valid & ex_ready;
  assign w_wb_wr   = wb_valid & (wb_rd != '0);

  // Regfile read and write ports
  assign rf_rs1   = r_rs1;
  assign rf_rs2   = r_rs2;
  assign rf_renb1 = (r_state == S_WAIT) & r_use1;
  assign rf_renb2 = (r_state == S_WAIT) & r_use2;
  assign rf_rd    = wb_rd;
  assign rf_wenb  = w_wb_wr;
  assign rf_wdata = wb_data;

  assign ex_valid = r_ex_valid;
  assign ex_op1   = r_ex_op1;
  assign ex_op2   = r_ex_op2;
  assign ex_rd    = r_ex_rd;
  assign ex_wr    = r_ex_wr;
  assign sb_err   = r_sb_err;

  // Pending bits as seen this cycle, with any arriving writeback already retired
  always_comb begin
    w_wb_hit = '0;
    if (wb_valid) w_wb_hit[wb_rd] = 1'b1;
    w_pend_eff = r_pend & ~w_wb_hit;
    w_hazard   = (r_use1 & w_pend_eff[r_rs1])
               | (r_use2 & w_pend_eff[r_rs2])
               | (r_wr & (r_rd != '0) & w_pend_eff[r_rd]);
  end

  // Operand select: unused or x0 reads zero, same-cycle writeback wins over regfile
  always_comb begin
    w_op1 = rf_rdata1;
    if (!r_use1 || r_rs1 == '0)          w_op1 = '0;
    else if (wb_valid && wb_rd == r_rs1) w_op1 = wb_data;
    w_op2 = rf_rdata2;
    if (!r_use2 || r_rs2 == '0)          w_op2 = '0;
    else if (wb_valid && wb_rd == r_rs2) w_op2 = wb_data;
  end

  // Issue FSM: capture instruction, wait out hazards, hold operands until execute takes them
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_use1     <= 1'b0;
      r_use2     <= 1'b0;
      r_wr       <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_op1   <= '0;
      r_ex_op2   <= '0;
      r_ex_rd    <= '0;
      r_ex_wr    <= 1'b0;
    end else begin
      if (w_id_fire) begin
        r_rs1  <= id_rs1;
        r_rs2  <= id_rs2;
        r_rd   <= id_rd;
        r_use1 <= id_use_rs1;
        r_use2 <= id_use_rs2;
        r_wr   <= id_wr;
      end
      case (r_state)
        S_IDLE: begin
          if (w_id_fire) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!w_hazard) begin
            r_ex_valid <= 1'b1;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
            r_ex_rd    <= r_rd;
            r_ex_wr    <= r_wr & (r_rd != '0);
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ex_ready) begin
            r_ex_valid <= 1'b0;
            r_state    <= w_id_fire ? S_WAIT : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scoreboard: issue sets, writeback clears (set wins); unexpected writeback is sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      if (w_wb_wr) begin
        if (!r_pend[wb_rd]) r_sb_err <= 1'b1;
        r_pend[wb_rd] <= 1'b0;
      end
      if (w_ex_fire && r_ex_wr) r_pend[r_ex_rd] <= 1'b1;
    end
  end

endmodule
`default_nettype wire
